// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the cache-to-memory arbiter.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    localparam logic [31:0] BUS_ERR_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/access_timer.sv
// Cycle counter bounding how long one RAM access may wait for ram_ready.
module access_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_r;

    // Count enabled cycles; clear between accesses and on reset.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            count_r <= '0;
        end else if (en) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // High in the cycle whose increment would reach TIMEOUT.
    assign expired = en && (count_r == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache and D-cache single-word requests onto one RAM port.
// Optional macro ARB_ROUND_ROBIN_EN replaces fixed D-over-I priority with round-robin.
import cpu_types_pkg::*;

module cache_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready,
    output logic              bus_err
);

    arb_state_t        state_r;
    grant_t            grant_r;
    logic              write_r;
    logic              pend_d_s;
    logic              pick_d_s;
    logic              held_s;
    logic              done_s;
    logic              expired_s;
    logic              timer_en_s;
    logic              timer_clr_s;
    logic [DATA_W-1:0] resp_word_s;
`ifdef ARB_ROUND_ROBIN_EN
    grant_t            last_grant_r;
`endif

    access_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (timer_clr_s),
        .en      (timer_en_s),
        .expired (expired_s)
    );

    // Grant selection, request-still-held check and response word.
    always_comb begin
        pend_d_s    = dREN || dWEN;
`ifdef ARB_ROUND_ROBIN_EN
        if (pend_d_s && iREN) begin
            pick_d_s = (last_grant_r == GRANT_I);
        end else begin
            pick_d_s = pend_d_s;
        end
`else
        pick_d_s    = pend_d_s;
`endif
        held_s      = (grant_r == GRANT_D) ? pend_d_s : iREN;
        done_s      = ram_ready || expired_s;
        timer_en_s  = (state_r == ACCESS);
        timer_clr_s = (state_r != ACCESS);
        if (!ram_ready) begin
            resp_word_s = DATA_W'(BUS_ERR_WORD);
        end else if (write_r) begin
            resp_word_s = ram_store;
        end else begin
            resp_word_s = ram_load;
        end
    end

    // Main FSM with registered RAM strobes and cache handshake outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= IDLE;
            grant_r   <= GRANT_I;
            write_r   <= 1'b0;
            iwait     <= 1'b1;
            dwait     <= 1'b1;
            iload     <= '0;
            dload     <= '0;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_store <= '0;
            bus_err   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_r <= GRANT_D;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    iwait <= 1'b1;
                    dwait <= 1'b1;
                    if (pend_d_s || iREN) begin
                        grant_r  <= pick_d_s ? GRANT_D : GRANT_I;
                        write_r  <= pick_d_s && dWEN;
                        ram_ren  <= !(pick_d_s && dWEN);
                        ram_wen  <= pick_d_s && dWEN;
                        ram_addr <= pick_d_s ? daddr : iaddr;
                        if (pick_d_s) begin
                            ram_store <= dstore;
                        end else begin
                            ram_store <= ram_store;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_r <= pick_d_s ? GRANT_D : GRANT_I;
`endif
                        state_r <= ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (done_s) begin
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        if (!ram_ready) begin
                            bus_err <= 1'b1;
                        end else begin
                            bus_err <= bus_err;
                        end
                        // A requester that gave up gets no wait pulse and keeps its old load.
                        if (held_s && (grant_r == GRANT_D)) begin
                            dwait <= 1'b0;
                            dload <= resp_word_s;
                        end else if (held_s) begin
                            iwait <= 1'b0;
                            iload <= resp_word_s;
                        end else begin
                            iwait <= 1'b1;
                            dwait <= 1'b1;
                        end
                        state_r <= RESP;
                    end else begin
                        state_r <= ACCESS;
                    end
                end
                RESP: begin
                    iwait   <= 1'b1;
                    dwait   <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    ram_ren <= 1'b0;
                    ram_wen <= 1'b0;
                    iwait   <= 1'b1;
                    dwait   <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter (default fixed-priority build, TIMEOUT=4).
module tb_cache_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = 32'h0;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = 32'h0;
    logic [31:0] dstore = 32'h0;
    logic        dwait;
    logic [31:0] dload;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_store;
    logic [31:0] ram_load = 32'h0;
    logic        ram_ready = 1'b0;
    logic        bus_err;

    int n_vec = 0;
    int n_err = 0;

    cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready),
        .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Called in the first strobe cycle; returns in the response cycle (strobe + lat + 1).
    task automatic ram_respond(input int lat, input logic [31:0] data);
        repeat (lat) tick();
        ram_ready = 1'b1;
        ram_load  = data;
        tick();
        ram_ready = 1'b0;
        ram_load  = 32'h0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        n_vec++; if (iwait !== 1'b1)     begin n_err++; $display("FAIL reset_iwait: got %b want 1", iwait); end
        n_vec++; if (dwait !== 1'b1)     begin n_err++; $display("FAIL reset_dwait: got %b want 1", dwait); end
        n_vec++; if (iload !== 32'h0)    begin n_err++; $display("FAIL reset_iload: got %h want 0", iload); end
        n_vec++; if (dload !== 32'h0)    begin n_err++; $display("FAIL reset_dload: got %h want 0", dload); end
        n_vec++; if ({ram_ren, ram_wen} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got %b want 00", {ram_ren, ram_wen}); end
        n_vec++; if (ram_addr !== 32'h0) begin n_err++; $display("FAIL reset_ram_addr: got %h want 0", ram_addr); end
        n_vec++; if (ram_store !== 32'h0) begin n_err++; $display("FAIL reset_ram_store: got %h want 0", ram_store); end
        n_vec++; if (bus_err !== 1'b0)   begin n_err++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
        RST = 1'b0;
    endtask

    task automatic test_iread();
        iREN = 1'b1; iaddr = 32'h40;
        tick();
        n_vec++; if (ram_ren !== 1'b1 || ram_wen !== 1'b0) begin n_err++; $display("FAIL iread_strobe: got ren=%b wen=%b want ren=1 wen=0", ram_ren, ram_wen); end
        n_vec++; if (ram_addr !== 32'h40) begin n_err++; $display("FAIL iread_addr: got %h want 40", ram_addr); end
        n_vec++; if (iwait !== 1'b1) begin n_err++; $display("FAIL iread_iwait_early: got %b want 1", iwait); end
        ram_respond(2, 32'h8C010004);
        n_vec++; if (iwait !== 1'b0) begin n_err++; $display("FAIL iread_iwait_cycle4: got %b want 0", iwait); end
        n_vec++; if (iload !== 32'h8C010004) begin n_err++; $display("FAIL iread_iload: got %h want 8c010004", iload); end
        n_vec++; if (dwait !== 1'b1) begin n_err++; $display("FAIL iread_dwait: got %b want 1", dwait); end
        n_vec++; if (ram_ren !== 1'b0) begin n_err++; $display("FAIL iread_ren_drop: got %b want 0", ram_ren); end
        iREN = 1'b0;
        tick();
        n_vec++; if (iwait !== 1'b1) begin n_err++; $display("FAIL iread_iwait_release: got %b want 1", iwait); end
        n_vec++; if (iload !== 32'h8C010004) begin n_err++; $display("FAIL iread_iload_hold: got %h want 8c010004", iload); end
    endtask

    task automatic test_dwrite();
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        tick();
        n_vec++; if (ram_wen !== 1'b1 || ram_ren !== 1'b0) begin n_err++; $display("FAIL dwrite_strobe: got ren=%b wen=%b want ren=0 wen=1", ram_ren, ram_wen); end
        n_vec++; if (ram_addr !== 32'h100) begin n_err++; $display("FAIL dwrite_addr: got %h want 100", ram_addr); end
        n_vec++; if (ram_store !== 32'hDEADBEEF) begin n_err++; $display("FAIL dwrite_store: got %h want deadbeef", ram_store); end
        ram_respond(1, 32'h12345678);
        n_vec++; if (dwait !== 1'b0) begin n_err++; $display("FAIL dwrite_dwait: got %b want 0", dwait); end
        n_vec++; if (dload !== 32'hDEADBEEF) begin n_err++; $display("FAIL dwrite_dload: got %h want deadbeef", dload); end
        n_vec++; if (iwait !== 1'b1) begin n_err++; $display("FAIL dwrite_iwait: got %b want 1", iwait); end
        dWEN = 1'b0;
        tick();
        n_vec++; if (dwait !== 1'b1) begin n_err++; $display("FAIL dwrite_dwait_release: got %b want 1", dwait); end
    endtask

    task automatic test_contention();
        iREN = 1'b1; iaddr = 32'h200;
        dREN = 1'b1; daddr = 32'h300;
        tick();
        n_vec++; if (ram_addr !== 32'h300 || ram_ren !== 1'b1) begin n_err++; $display("FAIL cont_d_first: got addr=%h ren=%b want addr=300 ren=1", ram_addr, ram_ren); end
        ram_respond(1, 32'h11111111);
        n_vec++; if (dwait !== 1'b0 || dload !== 32'h11111111) begin n_err++; $display("FAIL cont_d_resp: got dwait=%b dload=%h want 0/11111111", dwait, dload); end
        n_vec++; if (iwait !== 1'b1) begin n_err++; $display("FAIL cont_i_wait_held: got %b want 1", iwait); end
        dREN = 1'b0;
        tick();
        tick();
        n_vec++; if (ram_addr !== 32'h200 || ram_ren !== 1'b1) begin n_err++; $display("FAIL cont_i_second: got addr=%h ren=%b want addr=200 ren=1", ram_addr, ram_ren); end
        ram_respond(1, 32'h22222222);
        n_vec++; if (iwait !== 1'b0 || iload !== 32'h22222222) begin n_err++; $display("FAIL cont_i_resp: got iwait=%b iload=%h want 0/22222222", iwait, iload); end
        iREN = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        iREN = 1'b1; iaddr = 32'h40;
        tick();
        ram_respond(1, 32'h33333333);
        n_vec++; if (iwait !== 1'b0 || iload !== 32'h33333333) begin n_err++; $display("FAIL b2b_first: got iwait=%b iload=%h want 0/33333333", iwait, iload); end
        iaddr = 32'h44;
        tick();
        n_vec++; if (ram_ren !== 1'b0 || iwait !== 1'b1) begin n_err++; $display("FAIL b2b_idle_gap: got ren=%b iwait=%b want 0/1", ram_ren, iwait); end
        tick();
        n_vec++; if (ram_ren !== 1'b1 || ram_addr !== 32'h44) begin n_err++; $display("FAIL b2b_second_strobe: got ren=%b addr=%h want 1/44", ram_ren, ram_addr); end
        ram_respond(1, 32'h44444444);
        n_vec++; if (iwait !== 1'b0 || iload !== 32'h44444444) begin n_err++; $display("FAIL b2b_second: got iwait=%b iload=%h want 0/44444444", iwait, iload); end
        iREN = 1'b0;
        tick();
    endtask

    task automatic test_dropped();
        iREN = 1'b1; iaddr = 32'h80;
        tick();
        n_vec++; if (ram_ren !== 1'b1 || ram_addr !== 32'h80) begin n_err++; $display("FAIL drop_strobe: got ren=%b addr=%h want 1/80", ram_ren, ram_addr); end
        iREN = 1'b0;
        ram_respond(2, 32'h55555555);
        n_vec++; if (iwait !== 1'b1) begin n_err++; $display("FAIL drop_iwait: got %b want 1", iwait); end
        n_vec++; if (iload !== 32'h44444444) begin n_err++; $display("FAIL drop_iload: got %h want 44444444", iload); end
        n_vec++; if (ram_ren !== 1'b0) begin n_err++; $display("FAIL drop_ren_done: got %b want 0", ram_ren); end
        tick();
    endtask

    task automatic test_timeout();
        dREN = 1'b1; daddr = 32'h500;
        tick();
        n_vec++; if (ram_ren !== 1'b1) begin n_err++; $display("FAIL to_strobe: got %b want 1", ram_ren); end
        repeat (3) tick();
        n_vec++; if (ram_ren !== 1'b1 || bus_err !== 1'b0) begin n_err++; $display("FAIL to_fourth_cycle: got ren=%b bus_err=%b want 1/0", ram_ren, bus_err); end
        tick();
        n_vec++; if (ram_ren !== 1'b0) begin n_err++; $display("FAIL to_strobe_drop: got %b want 0", ram_ren); end
        n_vec++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL to_bus_err: got %b want 1", bus_err); end
        n_vec++; if (dwait !== 1'b0 || dload !== 32'hBAD1BAD1) begin n_err++; $display("FAIL to_resp: got dwait=%b dload=%h want 0/bad1bad1", dwait, dload); end
        dREN = 1'b0;
        tick();
        iREN = 1'b1; iaddr = 32'h10;
        tick();
        ram_respond(1, 32'h77777777);
        n_vec++; if (iwait !== 1'b0 || iload !== 32'h77777777) begin n_err++; $display("FAIL to_next_access: got iwait=%b iload=%h want 0/77777777", iwait, iload); end
        n_vec++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL to_bus_err_sticky: got %b want 1", bus_err); end
        iREN = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        iREN = 1'b1; iaddr = 32'h60;
        tick();
        n_vec++; if (ram_ren !== 1'b1) begin n_err++; $display("FAIL rmid_strobe: got %b want 1", ram_ren); end
        RST = 1'b1;
        tick();
        n_vec++; if (ram_ren !== 1'b0 || iwait !== 1'b1 || dwait !== 1'b1) begin n_err++; $display("FAIL rmid_abandon: got ren=%b iwait=%b dwait=%b want 0/1/1", ram_ren, iwait, dwait); end
        n_vec++; if (bus_err !== 1'b0 || iload !== 32'h0) begin n_err++; $display("FAIL rmid_cleared: got bus_err=%b iload=%h want 0/0", bus_err, iload); end
        RST = 1'b0;
        tick();
        n_vec++; if (ram_ren !== 1'b1 || ram_addr !== 32'h60) begin n_err++; $display("FAIL rmid_regrant: got ren=%b addr=%h want 1/60", ram_ren, ram_addr); end
        ram_respond(1, 32'h66666666);
        n_vec++; if (iwait !== 1'b0 || iload !== 32'h66666666) begin n_err++; $display("FAIL rmid_resp: got iwait=%b iload=%h want 0/66666666", iwait, iload); end
        iREN = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_iread();
        test_dwrite();
        test_contention();
        test_back_to_back();
        test_dropped();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
